// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master arbiter in front of a single-port bridge. Master 0 (CPU side)
//   and master 1 (DMA side) compete for the bus. The grant is registered and
//   the ack, bus mux and read-data return are combinational off that grant.
//   A locked owner keeps the bus for consecutive beats. If the other master is
//   waiting, the locked owner is forcibly released after MAX_HOLD beats and a
//   one-cycle preempt pulse is raised.
//
// Parameters
//   MAX_HOLD   maximum consecutive locked beats while the other master waits
//              (2..255)
//
// Ports
//   fpga_clk, fpga_rstn         clock, synchronous active-low reset
//   mX_req/lock/addr/we/wdata   per-master beat request (X = 0, 1)
//   mX_gnt                      registered grant
//   mX_ack                      beat completes this cycle (gnt & req)
//   mX_rdata                    Bus_rdata routed to the granted master, else 0
//   Bus_addr/we/wdata           beat driven to the bridge by the granted master
//   Bus_rdata                   same-cycle read data from the bridge
//   preempt                     one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        fpga_clk,
  input  logic        fpga_rstn,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] Bus_addr,
  output logic        Bus_we,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic        preempt
);

  // Last beat index a locked owner may use while the other master waits.
  localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_owner;
  logic        r_m0_gnt;
  logic        r_m1_gnt;
  logic        r_preempt;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  w_hold_nxt;
  logic        w_force;
  logic        w_ack_any;
  logic        w_bus_we;
  logic [31:0] w_bus_addr;
  logic [31:0] w_bus_wdata;

  // Next owner selection, including the forced release of a locked owner.
  always_comb begin
    w_state_nxt = r_state;
    w_force     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (m0_req && m1_req) begin
          w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
        end else if (m0_req) begin
          w_state_nxt = ST_OWN0;
        end else if (m1_req) begin
          w_state_nxt = ST_OWN1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!m0_req) begin
          w_state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
        end else if (!m1_req) begin
          w_state_nxt = ST_OWN0;
        end else if (!m0_lock) begin
          w_state_nxt = ST_OWN1;
        end else if (r_hold_cnt >= LP_HOLD_LAST) begin
          w_state_nxt = ST_OWN1;
          w_force     = 1'b1;
        end else begin
          w_state_nxt = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!m1_req) begin
          w_state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
        end else if (!m0_req) begin
          w_state_nxt = ST_OWN1;
        end else if (!m1_lock) begin
          w_state_nxt = ST_OWN0;
        end else if (r_hold_cnt >= LP_HOLD_LAST) begin
          w_state_nxt = ST_OWN0;
          w_force     = 1'b1;
        end else begin
          w_state_nxt = ST_OWN1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_force     = 1'b0;
      end
    endcase
  end

  assign w_ack_any = m0_ack | m1_ack;

  // Beat counter: restarts on any owner change or while idle, saturates.
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
      w_hold_nxt = 8'd0;
    end else if (w_ack_any && (r_hold_cnt < LP_HOLD_LAST)) begin
      w_hold_nxt = r_hold_cnt + 8'd1;
    end else begin
      w_hold_nxt = r_hold_cnt;
    end
  end

  // Owner state, grants, last owner, beat counter and preempt pulse.
  always_ff @(posedge fpga_clk) begin
    if (!fpga_rstn) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_m0_gnt     <= 1'b0;
      r_m1_gnt     <= 1'b0;
      r_hold_cnt   <= 8'd0;
      r_preempt    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_m0_gnt   <= (w_state_nxt == ST_OWN0);
      r_m1_gnt   <= (w_state_nxt == ST_OWN1);
      r_hold_cnt <= w_hold_nxt;
      r_preempt  <= w_force;
      if (w_state_nxt == ST_OWN0) begin
        r_last_owner <= 1'b0;
      end else if (w_state_nxt == ST_OWN1) begin
        r_last_owner <= 1'b1;
      end else begin
        r_last_owner <= r_last_owner;
      end
    end
  end

  // Bus mux from the granted master; zeros when nobody owns the bus.
  always_comb begin
    w_bus_addr  = 32'h0000_0000;
    w_bus_wdata = 32'h0000_0000;
    w_bus_we    = 1'b0;
    if (r_m0_gnt) begin
      w_bus_addr  = m0_addr;
      w_bus_wdata = m0_wdata;
      w_bus_we    = m0_we & m0_req;
    end else if (r_m1_gnt) begin
      w_bus_addr  = m1_addr;
      w_bus_wdata = m1_wdata;
      w_bus_we    = m1_we & m1_req;
    end else begin
      w_bus_addr  = 32'h0000_0000;
      w_bus_wdata = 32'h0000_0000;
      w_bus_we    = 1'b0;
    end
  end

  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;
  assign m0_ack    = r_m0_gnt & m0_req;
  assign m1_ack    = r_m1_gnt & m1_req;
  assign m0_rdata  = r_m0_gnt ? Bus_rdata : 32'h0000_0000;
  assign m1_rdata  = r_m1_gnt ? Bus_rdata : 32'h0000_0000;
  assign Bus_addr  = w_bus_addr;
  assign Bus_wdata = w_bus_wdata;
  // Writes are blocked while reset is held, even before the first reset edge
  // has cleared the grant registers.
  assign Bus_we    = w_bus_we & fpga_rstn;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed-vector bench for bus_arbiter (MAX_HOLD = 4). Each vector drives
//   the inputs for one cycle and pushes the expected outputs into a queue;
//   a monitor pops one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        fpga_clk;
  logic        fpga_rstn;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_we;
  logic        preempt;

  typedef struct {
    int          idx;
    logic        g0, g1, a0, a1, we, pre;
    logic [31:0] addr, wdata, rd0, rd1;
    int          hold;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_vec    = 0;

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .fpga_clk  (fpga_clk),
    .fpga_rstn (fpga_rstn),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .Bus_addr  (Bus_addr),
    .Bus_we    (Bus_we),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata),
    .preempt   (preempt)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be.
  // Grant/preempt/hold are hand-computed; ack, bus mux and rdata follow from
  // the expected grant and the driven inputs.
  task automatic step(input logic rst, input logic r0, input logic l0, input logic w0,
                      input logic r1, input logic l1, input logic w1, input logic [31:0] rd,
                      input logic e0, input logic e1, input logic ep, input int eh);
    exp_t e;
    @(posedge fpga_clk);
    #1;
    fpga_rstn = rst;
    m0_req = r0; m0_lock = l0; m0_we = w0;
    m1_req = r1; m1_lock = l1; m1_we = w1;
    Bus_rdata = rd;
    e.idx   = n_vec;
    e.g0    = e0;
    e.g1    = e1;
    e.pre   = ep;
    e.hold  = eh;
    e.a0    = e0 & r0;
    e.a1    = e1 & r1;
    e.we    = rst & ((e0 & w0 & r0) | (e1 & w1 & r1));
    e.addr  = e0 ? m0_addr  : (e1 ? m1_addr  : 32'h0000_0000);
    e.wdata = e0 ? m0_wdata : (e1 ? m1_wdata : 32'h0000_0000);
    e.rd0   = e0 ? rd : 32'h0000_0000;
    e.rd1   = e1 ? rd : 32'h0000_0000;
    exp_q.push_back(e);
    n_vec++;
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge.
  always @(negedge fpga_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.idx, "m0_gnt",    {31'd0, m0_gnt},   {31'd0, e.g0});
      chk(e.idx, "m1_gnt",    {31'd0, m1_gnt},   {31'd0, e.g1});
      chk(e.idx, "m0_ack",    {31'd0, m0_ack},   {31'd0, e.a0});
      chk(e.idx, "m1_ack",    {31'd0, m1_ack},   {31'd0, e.a1});
      chk(e.idx, "Bus_we",    {31'd0, Bus_we},   {31'd0, e.we});
      chk(e.idx, "preempt",   {31'd0, preempt},  {31'd0, e.pre});
      chk(e.idx, "Bus_addr",  Bus_addr,  e.addr);
      chk(e.idx, "Bus_wdata", Bus_wdata, e.wdata);
      chk(e.idx, "m0_rdata",  m0_rdata,  e.rd0);
      chk(e.idx, "m1_rdata",  m1_rdata,  e.rd1);
      if (e.hold >= 0) begin
        chk(e.idx, "hold_cnt", {24'd0, dut.r_hold_cnt}, e.hold);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fpga_rstn = 1'b0;
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
    m0_addr = 32'h0000_1000; m0_wdata = 32'hA5A5_0001;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b1;
    m1_addr = 32'h0000_0040; m1_wdata = 32'hDEAD_BEEF;
    Bus_rdata = 32'h0000_0000;
    // Before any clock edge: a write request under reset must not reach the bus.
    #1;
    chk(-1, "Bus_we_pre_reset", {31'd0, Bus_we}, 32'd0);

    // Reset state.
    step(1'b0, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);
    step(1'b0, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // Tie after reset: m0 first, then unlocked alternation 0,1,0,1.
    // m1_lock while m1 is not the owner has no effect.
    step(1'b1, 1,0,0, 1,0,0, 32'h0, 0,0,0, -1);
    step(1'b1, 1,0,0, 1,1,0, 32'h0, 1,0,0, 0);
    step(1'b1, 1,0,0, 1,0,0, 32'h0, 0,1,0, 0);
    step(1'b1, 1,0,0, 1,0,0, 32'h0, 1,0,0, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,1,0, -1);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // m1 alone writes 0xDEADBEEF to 0x40; then we held with req low.
    step(1'b1, 0,0,0, 1,0,1, 32'h0, 0,0,0, -1);
    step(1'b1, 0,0,0, 1,0,1, 32'h0, 0,1,0, 0);
    step(1'b1, 0,0,0, 0,0,1, 32'h0, 0,1,0, -1);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // m0 drops req while m1 waits: direct handover, then m1 read data.
    step(1'b1, 1,0,0, 0,0,0, 32'h0, 0,0,0, -1);
    step(1'b1, 1,1,0, 1,0,0, 32'h0, 1,0,0, 0);
    step(1'b1, 0,0,0, 1,0,0, 32'h0000_1234, 1,0,0, -1);
    step(1'b1, 0,0,0, 1,0,0, 32'h0000_1234, 0,1,0, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0000_1234, 0,1,0, -1);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // Locked m0 burst against a waiting m1: 4 beats, then forced release.
    step(1'b1, 1,1,0, 1,0,0, 32'h0, 0,0,0, -1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1,1,0, 1,0,0, 32'h0, 1,0,0, k);
    end
    step(1'b1, 1,1,0, 1,0,0, 32'h0, 0,1,1, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 1,0,0, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // Locked m0 burst with m1 idle: 40 beats, counter saturates, no preempt.
    step(1'b1, 1,1,0, 0,0,0, 32'h0, 0,0,0, -1);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1,1,0, 0,0,0, 32'h0, 1,0,0, (k < 3) ? k : 3);
    end
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 1,0,0, 3);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // Reset on beat 2 of a locked m1 write burst, then tie goes to m0.
    step(1'b1, 0,0,0, 1,1,1, 32'h0, 0,0,0, -1);
    step(1'b1, 0,0,0, 1,1,1, 32'h0, 0,1,0, 0);
    step(1'b0, 0,0,0, 1,1,1, 32'h0, 0,1,0, -1);
    step(1'b0, 1,0,0, 1,0,0, 32'h0, 0,0,0, 0);
    step(1'b1, 1,0,0, 1,0,0, 32'h0, 0,0,0, 0);
    step(1'b1, 1,0,0, 1,0,0, 32'h0, 1,0,0, 0);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,1,0, -1);
    step(1'b1, 0,0,0, 0,0,0, 32'h0, 0,0,0, 0);

    // Let the monitor drain the queue, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      @(posedge fpga_clk);
    end
    chk(-1, "queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
